vga_timing_gen: RTL and testbench

// - Source end of the pixel-coordinate interface: generates the scan position (x, y) and the VGA

---
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Pixel-coordinate bus between the VGA timing source and its
//               consumers (pixel renderer, monitor output stage).
//               master : driven by vga_timing_gen
//               slave  : observed by consumers
// Signals     : x, y        16-bit scan position
//               hsync/vsync sync strobes (level SYNC_POL while asserted)
//               video_on    inside active window
//               pix_en      counters advance at the next clk edge
//               line_start  1-clk pulse on first cycle of a new line
//               frame_start 1-clk pulse on first cycle of a new frame
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
   logic [15:0] x;
   logic [15:0] y;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        pix_en;
   logic        line_start;
   logic        frame_start;

   modport master (
      output x, y, hsync, vsync, video_on, pix_en, line_start, frame_start
   );

   modport slave (
      input  x, y, hsync, vsync, video_on, pix_en, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA scan-position and sync generator. One coordinate space per
//               axis: sync pulse from count 0, then back porch, active, front
//               porch. Every output is a flop; sync/video_on are decoded from
//               the next-state counters so they line up with the x/y shown.
// Ports       : clk    - system clock
//               reset  - synchronous, active-low
//               vga_o  - vga_timing_gen_if.master (x, y, hsync, vsync,
//                        video_on, pix_en, line_start, frame_start)
// Options     : VGA_CLKDIV_EN - pixel clock is clk/2 (pix_en toggles every
//               clk, resets to 0). Undefined: pix_en is constantly 1.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int unsigned H_TOTAL   = 800,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_ACT_BEG = 144,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_TOTAL   = 525,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_ACT_BEG = 35,
   parameter int unsigned V_ACTIVE  = 480,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  wire logic         clk,
   input  wire logic         reset,
   vga_timing_gen_if.master  vga_o
);

   localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_SW    = 16'(H_SYNC);
   localparam logic [15:0] V_SW    = 16'(V_SYNC);
   localparam logic [15:0] H_AB    = 16'(H_ACT_BEG);
   localparam logic [15:0] H_AE    = 16'(H_ACT_BEG + H_ACTIVE);
   localparam logic [15:0] V_AB    = 16'(V_ACT_BEG);
   localparam logic [15:0] V_AE    = 16'(V_ACT_BEG + V_ACTIVE);

   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        video_on_q, video_on_d;
   logic        pix_en_q, pix_en_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;

`ifdef VGA_CLKDIV_EN
   // Toggle flop divides clk by two; first high cycle is the 2nd after reset.
   localparam logic PIX_EN_RST = 1'b0;
   assign pix_en_d = ~pix_en_q;
`else
   localparam logic PIX_EN_RST = 1'b1;
   assign pix_en_d = 1'b1;
`endif

   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      // Pulses are raised only on the advancing edge, so with the divider
      // enabled they last one clk even though x is held for two.
      if (pix_en_q) begin
         if (x_q == H_LAST) begin
            x_d          = 16'd0;
            line_start_d = 1'b1;
            if (y_q == V_LAST) begin
               y_d           = 16'd0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 16'd1;
            end
         end else begin
            x_d = x_q + 16'd1;
         end
      end

      // Decode from next-state counters: zero latency relative to x/y.
      hsync_d    = (x_d < H_SW) ? SYNC_POL : ~SYNC_POL;
      vsync_d    = (y_d < V_SW) ? SYNC_POL : ~SYNC_POL;
      video_on_d = (x_d >= H_AB) && (x_d < H_AE) && (y_d >= V_AB) && (y_d < V_AE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q           <= 16'd0;
         y_q           <= 16'd0;
         hsync_q       <= SYNC_POL;
         vsync_q       <= SYNC_POL;
         video_on_q    <= 1'b0;
         pix_en_q      <= PIX_EN_RST;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pix_en_q      <= pix_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_o.x           = x_q;
   assign vga_o.y           = y_q;
   assign vga_o.hsync       = hsync_q;
   assign vga_o.vsync       = vsync_q;
   assign vga_o.video_on    = video_on_q;
   assign vga_o.pix_en      = pix_en_q;
   assign vga_o.line_start  = line_start_q;
   assign vga_o.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Testbench for vga_timing_gen. Two instances: one with default
//               640x480@60 timing for line-level boundaries, one with a small
//               raster for frame-level behaviour and random reset stimulus.
//               Expected values come from a pixel-count model: the number of
//               pixel advances since reset determines x/y by division.
// Options     : VGA_CLKDIV_EN - same meaning as in the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_CLKDIV_EN
   localparam int unsigned DIV    = 2;
   localparam logic        PE_RST = 1'b0;
`else
   localparam int unsigned DIV    = 1;
   localparam logic        PE_RST = 1'b1;
`endif
   localparam logic POL = 1'b0;

   // Small raster: 20 x 10, frame = 200 pixels, 12 x 5 active.
   localparam int unsigned S_HT = 20, S_HS = 3, S_HAB = 5, S_HA = 12;
   localparam int unsigned S_VT = 10, S_VS = 2, S_VAB = 3, S_VA = 5;
   localparam int unsigned S_FRAME = S_HT * S_VT;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic        hs;
      logic        vs;
      logic        von;
      logic        pe;
      logic        ls;
      logic        fs;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_f;
   logic        reset_s;
   int          checks = 0;
   int          errors = 0;
   int unsigned t_f = 0;
   int unsigned t_s = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if vga_f ();
   vga_timing_gen_if vga_s ();

   vga_timing_gen dut_f (
      .clk   (clk),
      .reset (reset_f),
      .vga_o (vga_f.master)
   );

   vga_timing_gen #(
      .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_BEG(S_HAB), .H_ACTIVE(S_HA),
      .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_BEG(S_VAB), .V_ACTIVE(S_VA),
      .SYNC_POL(POL)
   ) dut_s (
      .clk   (clk),
      .reset (reset_s),
      .vga_o (vga_s.master)
   );

   // Clocks elapsed since the last reset edge.
   always @(posedge clk) begin
      t_f <= reset_f ? t_f + 1 : 0;
      t_s <= reset_s ? t_s + 1 : 0;
   end

   // Reference: t clocks after reset -> p = t/DIV pixels advanced.
   function automatic exp_t model(input int unsigned t,
                                  input int unsigned ht, input int unsigned hsw,
                                  input int unsigned hab, input int unsigned ha,
                                  input int unsigned vt, input int unsigned vsw,
                                  input int unsigned vab, input int unsigned va);
      exp_t        e;
      int unsigned p, x, y;
      p     = t / DIV;
      x     = p % ht;
      y     = (p / ht) % vt;
      e.x   = 16'(x);
      e.y   = 16'(y);
      e.hs  = (x < hsw) ? POL : ~POL;
      e.vs  = (y < vsw) ? POL : ~POL;
      e.von = (x >= hab) && (x < hab + ha) && (y >= vab) && (y < vab + va);
      e.pe  = (DIV == 1) ? 1'b1 : ((t % 2) == 1);
      e.ls  = (p > 0) && (x == 0) && ((t % DIV) == 0);
      e.fs  = e.ls && (y == 0);
      return e;
   endfunction

   function automatic exp_t obs_s();
      return {vga_s.x, vga_s.y, vga_s.hsync, vga_s.vsync, vga_s.video_on,
              vga_s.pix_en, vga_s.line_start, vga_s.frame_start};
   endfunction

   function automatic exp_t obs_f();
      return {vga_f.x, vga_f.y, vga_f.hsync, vga_f.vsync, vga_f.video_on,
              vga_f.pix_en, vga_f.line_start, vga_f.frame_start};
   endfunction

   task automatic test_reset();
      exp_t want;
      reset_f = 1'b0;
      reset_s = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      want = {16'd0, 16'd0, POL, POL, 1'b0, PE_RST, 1'b0, 1'b0};
      checks++;
      if (obs_f() !== want) begin
         errors++;
         $display("FAIL reset_full got %h want %h", obs_f(), want);
      end
      checks++;
      if (obs_s() !== want) begin
         errors++;
         $display("FAIL reset_small got %h want %h", obs_s(), want);
      end
   endtask

   task automatic test_hsync_width();
      int cnt = 0;
      reset_f = 1'b1;
      while (vga_f.hsync === POL && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt != 96 * DIV) begin
         errors++;
         $display("FAIL hsync_width got %0d want %0d", cnt, 96 * DIV);
      end
      checks++;
      if (vga_f.x !== 16'd96) begin
         errors++;
         $display("FAIL hsync_deassert_x got %0d want 96", vga_f.x);
      end
   endtask

   task automatic test_line_wrap();
      int cnt = 0;
      while (!(vga_f.x === 16'd799 && vga_f.y === 16'd10) && cnt < 40000) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt >= 40000 || vga_f.hsync !== ~POL) begin
         errors++;
         $display("FAIL line_wrap_reach got x=%0d y=%0d hs=%b want x=799 y=10 hs=%b",
                  vga_f.x, vga_f.y, vga_f.hsync, ~POL);
      end
      repeat (DIV) @(negedge clk);
      checks++;
      if ({vga_f.x, vga_f.y, vga_f.line_start, vga_f.frame_start, vga_f.hsync}
          !== {16'd0, 16'd11, 1'b1, 1'b0, POL}) begin
         errors++;
         $display("FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b hs=%b want x=0 y=11 ls=1 fs=0 hs=%b",
                  vga_f.x, vga_f.y, vga_f.line_start, vga_f.frame_start, vga_f.hsync, POL);
      end
      @(negedge clk);
      checks++;
      if (vga_f.line_start !== 1'b0) begin
         errors++;
         $display("FAIL line_start_width got %b want 0", vga_f.line_start);
      end
   endtask

   task automatic test_active_window();
      int cnt = 0;
      int act = 0;
      while (!(vga_f.x === 16'd143 && vga_f.y === 16'd35) && cnt < 40000) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt >= 40000 || vga_f.video_on !== 1'b0) begin
         errors++;
         $display("FAIL active_pre got x=%0d y=%0d von=%b want x=143 y=35 von=0",
                  vga_f.x, vga_f.y, vga_f.video_on);
      end
      repeat (DIV) @(negedge clk);
      checks++;
      if ({vga_f.x, vga_f.video_on} !== {16'd144, 1'b1}) begin
         errors++;
         $display("FAIL active_first got x=%0d von=%b want x=144 von=1", vga_f.x, vga_f.video_on);
      end
      while (vga_f.video_on === 1'b1 && act < 5000) begin
         @(negedge clk);
         act++;
      end
      checks++;
      if (act != 640 * DIV || vga_f.x !== 16'd784) begin
         errors++;
         $display("FAIL active_line got cnt=%0d end_x=%0d want cnt=%0d end_x=784",
                  act, vga_f.x, 640 * DIV);
      end
   endtask

   task automatic test_midframe_reset();
      exp_t want;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      reset_f = 1'b0;
      @(negedge clk);
      reset_f = 1'b1;
      want = {16'd0, 16'd0, POL, POL, 1'b0, PE_RST, 1'b0, 1'b0};
      checks++;
      if (obs_f() !== want) begin
         errors++;
         $display("FAIL midframe_reset got %h want %h", obs_f(), want);
      end
      repeat (3) begin
         @(negedge clk);
         want = model(t_f, 800, 96, 144, 640, 525, 2, 35, 480);
         checks++;
         if (obs_f() !== want) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs_f(), want);
         end
      end
   endtask

   task automatic test_frame_wrap();
      int unsigned fs_t[$];
      int unsigned n_cyc;
      int          von_cnt = 0;
      int          vs_cnt  = 0;
      exp_t        want;
      n_cyc   = 3 * S_FRAME * DIV;
      reset_s = 1'b1;
      for (int unsigned n = 0; n <= n_cyc; n++) begin
         want = model(n, S_HT, S_HS, S_HAB, S_HA, S_VT, S_VS, S_VAB, S_VA);
         checks++;
         if (obs_s() !== want) begin
            errors++;
            $display("FAIL frame_cycle t=%0d got %h want %h", n, obs_s(), want);
         end
         if (vga_s.frame_start === 1'b1) fs_t.push_back(n);
         if (n < n_cyc) begin
            if (vga_s.video_on === 1'b1) von_cnt++;
            if (vga_s.vsync === POL) vs_cnt++;
         end
         @(negedge clk);
      end
      checks++;
      if (fs_t.size() != 3) begin
         errors++;
         $display("FAIL frame_start_count got %0d want 3", fs_t.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (fs_t[k] != (k + 1) * S_FRAME * DIV) begin
               errors++;
               $display("FAIL frame_start_time got %0d want %0d", fs_t[k], (k + 1) * S_FRAME * DIV);
            end
         end
      end
      checks++;
      if (von_cnt != 3 * S_HA * S_VA * DIV) begin
         errors++;
         $display("FAIL active_per_frame got %0d want %0d", von_cnt, 3 * S_HA * S_VA * DIV);
      end
      checks++;
      if (vs_cnt != 3 * S_VS * S_HT * DIV) begin
         errors++;
         $display("FAIL vsync_width got %0d want %0d", vs_cnt, 3 * S_VS * S_HT * DIV);
      end
   endtask

   task automatic test_random_reset();
      exp_t want;
      for (int i = 0; i < 3000; i++) begin
         want = model(t_s, S_HT, S_HS, S_HAB, S_HA, S_VT, S_VS, S_VAB, S_VA);
         checks++;
         if (obs_s() !== want) begin
            errors++;
            $display("FAIL random_cycle i=%0d got %h want %h", i, obs_s(), want);
         end
         reset_s = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      reset_s = 1'b1;
   endtask

   initial begin
      test_reset();
      test_frame_wrap();
      test_random_reset();
      test_hsync_width();
      test_line_wrap();
      test_active_window();
      test_midframe_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
